morse_entry: RTL and testbench

//  Parametrised player-entry accumulator for the morse game.
//  - Collects decoded dot/line pulses into a right-aligned 2-bit-per-symbol

---
 rtl/morse_entry.sv | 120 ++++++++++++
 tb/tb_morse_entry.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/morse_entry.sv
// Player-entry accumulator: collects dot/line symbols into a right-aligned code
// word, judges it against target and tracks failed attempts up to a lockout.
// Optional feature: define MORSE_ENTRY_UNDO_EN to enable the undo input.
//
// state  | meaning
// ENTRY  | accepting symbols, word not yet full
// FULL   | MAX_SYMS held; further symbols are dropped and set overflow
// LOCKED | MAX_ATTEMPTS consecutive wrong judgements; frozen until reset
module morse_entry #(
  parameter int MAX_SYMS     = 5,
  parameter int CNT_W        = 3,
  parameter int ATTEMPT_W    = 2,
  parameter int MAX_ATTEMPTS = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  ld_dot,
  input  logic                  ld_line,
  input  logic                  undo,
  input  logic                  done_input,
  input  logic [2*MAX_SYMS-1:0] target,
  output logic [2*MAX_SYMS-1:0] q,
  output logic [CNT_W-1:0]      sym_count,
  output logic                  overflow,
  output logic                  result_valid,
  output logic                  correct,
  output logic [ATTEMPT_W-1:0]  attempts,
  output logic                  locked
);

  localparam int W = 2 * MAX_SYMS;
  localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(MAX_SYMS);
  localparam logic [ATTEMPT_W-1:0] ATT_MAX = ATTEMPT_W'(MAX_ATTEMPTS);

  typedef enum logic [1:0] {ENTRY, FULL, LOCKED} state_t;

  state_t               state, state_nx;
  logic [W-1:0]         q_nx;
  logic [CNT_W-1:0]     cnt_nx;
  logic                 ovf_nx, rv_nx, cor_nx;
  logic [ATTEMPT_W-1:0] att_nx;
  logic                 sym_ok, match;
  logic [1:0]           sym;

`ifndef MORSE_ENTRY_UNDO_EN
  logic unused_undo;
  assign unused_undo = undo;
`endif

  assign sym_ok = ld_dot ^ ld_line;
  assign sym    = ld_line ? 2'b11 : 2'b01;
  assign match  = (q == target) && !overflow;
  assign locked = (state == LOCKED);

  always_comb begin
    state_nx = state;
    q_nx     = q;
    cnt_nx   = sym_count;
    ovf_nx   = overflow;
    rv_nx    = 1'b0;
    cor_nx   = correct;
    att_nx   = attempts;
    case (state)
      ENTRY, FULL: begin
        // done has priority; a symbol or undo in the same cycle is lost
        if (done_input) begin
          rv_nx    = 1'b1;
          cor_nx   = match;
          q_nx     = '0;
          cnt_nx   = '0;
          ovf_nx   = 1'b0;
          state_nx = ENTRY;
          if (match) begin
            att_nx = '0;
          end else begin
            if (attempts < ATT_MAX) att_nx = attempts + 1'b1;
            if (att_nx == ATT_MAX) state_nx = LOCKED;
          end
        end else if (sym_ok) begin
          if (state == FULL) begin
            ovf_nx = 1'b1;
          end else begin
            q_nx   = {q[W-3:0], sym};
            cnt_nx = sym_count + 1'b1;
            if (cnt_nx == CNT_MAX) state_nx = FULL;
          end
        end
`ifdef MORSE_ENTRY_UNDO_EN
        else if (undo && (sym_count != '0)) begin
          q_nx     = q >> 2;
          cnt_nx   = sym_count - 1'b1;
          state_nx = ENTRY;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state        <= ENTRY;
      q            <= '0;
      sym_count    <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      correct      <= 1'b0;
      attempts     <= '0;
    end else begin
      state        <= state_nx;
      q            <= q_nx;
      sym_count    <= cnt_nx;
      overflow     <= ovf_nx;
      result_valid <= rv_nx;
      correct      <= cor_nx;
      attempts     <= att_nx;
    end
  end

endmodule

// File: tb/tb_morse_entry.sv
// Self-checking bench for morse_entry: a symbol-list model compared every
// cycle, plus directed literal checks (honours MORSE_ENTRY_UNDO_EN).
module tb_morse_entry;
  localparam int MAX_SYMS = 5;
  localparam int W        = 2 * MAX_SYMS;
  localparam int MAX_ATT  = 3;

  logic         clock = 1'b0;
  logic         resetn, ld_dot, ld_line, undo, done_input;
  logic [W-1:0] target;
  logic [W-1:0] q;
  logic [2:0]   sym_count;
  logic         overflow, result_valid, correct, locked;
  logic [1:0]   attempts;

  int n_checks = 0;
  int n_fail   = 0;

  morse_entry #(.MAX_SYMS(MAX_SYMS), .CNT_W(3), .ATTEMPT_W(2), .MAX_ATTEMPTS(MAX_ATT)) dut (
    .clock(clock), .resetn(resetn), .ld_dot(ld_dot), .ld_line(ld_line),
    .undo(undo), .done_input(done_input), .target(target), .q(q),
    .sym_count(sym_count), .overflow(overflow), .result_valid(result_valid),
    .correct(correct), .attempts(attempts), .locked(locked)
  );

  always #5 clock = ~clock;

`ifdef MORSE_ENTRY_UNDO_EN
  localparam bit UNDO_EN = 1'b1;
`else
  localparam bit UNDO_EN = 1'b0;
`endif

  // model: list of entered symbols, first entered ends up most significant
  int m_syms[MAX_SYMS];
  int m_n, m_att;
  bit m_ovf, m_rv, m_cor, m_lock, started;

  function automatic logic [W-1:0] m_q();
    logic [W-1:0] v = '0;
    for (int i = 0; i < m_n; i++) v = (v << 2) | W'(m_syms[i]);
    return v;
  endfunction

  always @(posedge clock) begin
    started = 1'b1;
    if (!resetn) begin
      m_n = 0; m_att = 0; m_ovf = 0; m_rv = 0; m_cor = 0; m_lock = 0;
    end else if (m_lock) begin
      m_rv = 0;
    end else begin
      m_rv = 0;
      if (done_input) begin
        m_cor = (m_q() == target) && !m_ovf;
        if (m_cor) m_att = 0;
        else begin
          m_att = (m_att + 1 > MAX_ATT) ? MAX_ATT : m_att + 1;
          if (m_att == MAX_ATT) m_lock = 1;
        end
        m_n = 0; m_ovf = 0; m_rv = 1;
      end else if (ld_dot != ld_line) begin
        if (m_n == MAX_SYMS) m_ovf = 1;
        else begin m_syms[m_n] = ld_line ? 3 : 1; m_n++; end
      end else if (undo && UNDO_EN && m_n > 0) begin
        m_n--;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (started) begin
      chk("m_q", 32'(q), 32'(m_q()));
      chk("m_count", 32'(sym_count), 32'(m_n));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
      chk("m_result_valid", 32'(result_valid), 32'(m_rv));
      chk("m_correct", 32'(correct), 32'(m_cor));
      chk("m_attempts", 32'(attempts), 32'(m_att));
      chk("m_locked", 32'(locked), 32'(m_lock));
    end
  end

  // inputs held across one posedge; returns 1 time unit after the edge
  task automatic step(input bit d, input bit l, input bit u, input bit dn);
    ld_dot = d; ld_line = l; undo = u; done_input = dn;
    @(posedge clock); #1;
    ld_dot = 0; ld_line = 0; undo = 0; done_input = 0;
  endtask

  task automatic do_reset();
    resetn = 0; step(0, 0, 0, 0); resetn = 1;
  endtask

  initial begin
    resetn = 0; ld_dot = 0; ld_line = 0; undo = 0; done_input = 0; target = '0;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    chk("reset_q", 32'(q), 0);
    chk("reset_locked", 32'(locked), 0);
    resetn = 1;

    // 1: dot,line,dot matches
    step(1, 0, 0, 0); step(0, 1, 0, 0); step(1, 0, 0, 0);
    chk("t1_q", 32'(q), 32'h01D);
    target = 10'h01D; step(0, 0, 0, 1);
    chk("t1_rv", 32'(result_valid), 1);
    chk("t1_correct", 32'(correct), 1);
    chk("t1_q_clear", 32'(q), 0);
    step(0, 0, 0, 0);
    chk("t1_rv_pulse", 32'(result_valid), 0);

    // 2: six dots, overflow forces failure
    repeat (5) step(1, 0, 0, 0);
    chk("t2_count", 32'(sym_count), 5);
    chk("t2_q", 32'(q), 32'h155);
    step(1, 0, 0, 0);
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_q_kept", 32'(q), 32'h155);
    target = 10'h155; step(0, 0, 0, 1);
    chk("t2_correct", 32'(correct), 0);
    chk("t2_attempts", 32'(attempts), 1);
    chk("t2_ovf_clear", 32'(overflow), 0);

    // empty word judged normally, correct clears attempts
    target = '0; step(0, 0, 0, 1);
    chk("empty_correct", 32'(correct), 1);
    chk("empty_attempts", 32'(attempts), 0);

    // 3: lockout after three wrong judges
    target = 10'h001;
    step(0, 0, 0, 1); chk("t3_att1", 32'(attempts), 1);
    step(0, 0, 0, 1); chk("t3_att2", 32'(attempts), 2);
    chk("t3_not_locked", 32'(locked), 0);
    step(0, 0, 0, 1); chk("t3_att3", 32'(attempts), 3);
    chk("t3_locked", 32'(locked), 1);
    step(1, 0, 0, 0); step(0, 0, 0, 1);
    chk("t3_frozen_q", 32'(q), 0);
    chk("t3_frozen_rv", 32'(result_valid), 0);
    chk("t3_frozen_lock", 32'(locked), 1);
    do_reset();
    chk("t3_reset_att", 32'(attempts), 0);
    chk("t3_reset_lock", 32'(locked), 0);

    // 4: simultaneous events
    step(1, 1, 0, 0);
    chk("t4_both_count", 32'(sym_count), 0);
    step(1, 0, 0, 0);
    target = 10'h001; step(1, 0, 0, 1);
    chk("t4_done_wins", 32'(correct), 1);
    chk("t4_done_clear", 32'(sym_count), 0);

    // 5: undo
    step(0, 1, 0, 0); step(1, 0, 0, 0); step(0, 0, 1, 0);
    chk("t5_undo_q", 32'(q), UNDO_EN ? 32'h003 : 32'h00D);
    chk("t5_undo_cnt", 32'(sym_count), UNDO_EN ? 1 : 2);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    chk("t5_undo2_q", 32'(q), UNDO_EN ? 0 : 32'h00D);
    step(1, 0, 1, 0);
    chk("t5_sym_over_undo", 32'(q), UNDO_EN ? 32'h001 : 32'h035);
    do_reset();
    repeat (6) step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("t5_full_undo_cnt", 32'(sym_count), UNDO_EN ? 4 : 5);
    chk("t5_full_undo_ovf", 32'(overflow), 1);
    step(0, 1, 0, 0);
    chk("t5_full_undo_q", 32'(q), UNDO_EN ? 32'h157 : 32'h155);
    do_reset();

    // 6: reset mid-word
    repeat (3) step(1, 0, 0, 0);
    chk("t6_pre", 32'(sym_count), 3);
    resetn = 0; step(0, 0, 0, 1); resetn = 1;
    chk("t6_q", 32'(q), 0);
    chk("t6_count", 32'(sym_count), 0);
    chk("t6_rv", 32'(result_valid), 0);
    step(0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
